load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-side initiator between the execute stage and the data memory.
- Accepts one load or store request per transaction through a valid/ready handshake and drives the data memory's MemRead/MemWr/addr/funct3/write_data interface.
- Aligned accesses complete in one memory cycle. Misaligned halfword/word accesses are split into sequential byte accesses, and load results are reassembled and extended.
- Returns a one-cycle response pulse to the pipeline.

Parameters:
- ADDR_W, 12, byte-address width shared with data memory; byte addresses wrap modulo 2^ADDR_W.
- SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte accesses; 0 = reject misaligned accesses with resp_err.

Ports:
- clk  input  1  clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (IDLE only)
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V load/store funct3
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load result; 0 for stores and errors
- resp_err  output  1  illegal funct3 or rejected misaligned access; valid with resp_valid
- mem_MemRead  output  1  memory read enable
- mem_MemWr  output  1  memory write enable
- mem_addr  output  ADDR_W  memory byte address
- mem_funct3  output  3  memory access width code
- mem_write_data  output  32  memory write data
- mem_data_read  input  32  combinational read data from memory

Behaviour:
- Reset values: req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; all mem_* outputs 0. Reset is asynchronous: assertion mid-operation aborts immediately, mem_MemWr drops the same instant, and bytes already written stay written.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1. On req_valid at a clock edge, register store, funct3, addr, wdata.
  - Compute size (1/2/4) and aligned = (addr mod size == 0).
  - Illegal funct3 (loads 3/6/7, stores >=3), or misaligned with SPLIT_MISALIGNED=0 -> go to RESP with err=1.
  - Otherwise load byte counter k=0 and n=1 if aligned, else n=size; go to ACCESS.
- ACCESS (one cycle per k):
  - Aligned access: mem_addr=addr, mem_funct3=funct3 (loads use the stored funct3 as-is).
  - Split access: mem_addr = addr+k (wraps), mem_funct3 = 3'd4 (lbu) for loads, 3'd0 (sb) for stores; mem_write_data = {24'b0, wdata[8k+7:8k]}.
  - Loads sample mem_data_read at the end of each ACCESS cycle: aligned loads capture the full word; split loads place byte k into assembly bits [8k+7:8k].
  - k increments each cycle; after k=n-1, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; all mem_* outputs 0; then go to IDLE.
  - Split load extension: lh sign-extends from bit 15; lhu zero-extends; lw uses all 32 bits.
- Latency, counting the accept edge as cycle 0:
  - Aligned access: ACCESS in cycle 1, resp_valid in cycle 2.
  - Split access of n bytes: resp_valid in cycle n+1.
  - Error: resp_valid in cycle 1, with no memory cycle.
- Single outstanding request. req_valid is ignored outside IDLE. No backpressure on the response.
- mem_MemRead and mem_MemWr are never both 1, and both are 0 outside ACCESS.

Decomposition:
- Package lsu_pkg:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - State enum lsu_state_t {IDLE, ACCESS, RESP}.
  - Function size_of(funct3).
- Sub-module lsu_load_extend: combinational; inputs funct3 and the 32-bit assembled value; output is the sign- or zero-extended result. Used for split loads.

Test Plan:
- Aligned lw at 0x010, memory word 0x8899AABB -> one cycle with MemRead=1, funct3=2, addr=0x010; resp_valid at cycle 2; rdata=0x8899AABB; err=0.
- Misaligned lw at 0x013, bytes 0x013..0x016 = 11,22,33,44 -> four lbu cycles at 0x013, 0x014, 0x015, 0x016; resp_valid at cycle 5; rdata=0x44332211.
- Misaligned lh at 0x003, byte 0x003=0x80 and byte 0x004=0xFF -> rdata=0xFFFFFF80. The same access as lhu -> rdata=0x0000FF80.
- Misaligned sw at 0xFFE, wdata 0xDEADBEEF -> sb of EF at 0xFFE, BE at 0xFFF, AD at 0x000, DE at 0x001 (wrap); the memory afterwards matches; resp rdata=0.
- Load with funct3=3 -> no MemRead ever asserted; resp_valid at cycle 1 with err=1 and rdata=0. With SPLIT_MISALIGNED=0, lw at 0x001 -> same response.
- n_rst asserted during the second byte of the 0xFFE sw -> MemWr drops immediately, resp_valid never asserted, byte 0xFFE=EF retained, byte 0x000 unchanged; req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V load/store funct3 codes,
// FSM state encoding and access-size helpers.
package lsu_pkg;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;
   localparam logic [2:0] SB  = 3'd0;
   localparam logic [2:0] SH  = 3'd1;
   localparam logic [2:0] SW  = 3'd2;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } lsu_state_t;

   // Access size in bytes (1, 2 or 4); the low two funct3 bits encode the width.
   function automatic logic [2:0] size_of(input logic [2:0] funct3);
      case (funct3[1:0])
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
      if (store) begin
         return funct3 <= SW;
      end
      return (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of an assembled little-endian load value according to
// the RISC-V load funct3.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [31:0] value_i,
   output logic [31:0] result_o
);

   always_comb begin
      case (funct3_i)
         LB:      result_o = {{24{value_i[7]}}, value_i[7:0]};
         LH:      result_o = {{16{value_i[15]}}, value_i[15:0]};
         LBU:     result_o = {24'd0, value_i[7:0]};
         LHU:     result_o = {16'd0, value_i[15:0]};
         default: result_o = value_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, drives the data memory and
// splits misaligned halfword/word accesses into byte accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W           = 12,
   parameter bit SPLIT_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_MemRead,
   output logic              mem_MemWr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_funct3,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_data_read
);

   lsu_state_t        state_q, state_d;
   logic              store_q, store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        k_q, k_d;
   logic [1:0]        last_q, last_d;     // index of the final memory cycle (n-1)
   logic              split_q, split_d;
   logic              err_q, err_d;
   logic [31:0]       asm_q, asm_d;

   logic [2:0]  req_size;
   logic        req_aligned;
   logic [4:0]  byte_lsb;
   logic [31:0] ext_rdata;

   assign req_size    = size_of(req_funct3);
   assign req_aligned = (req_size == 3'd1)
                     || ((req_size == 3'd2) && !req_addr[0])
                     || ((req_size == 3'd4) && (req_addr[1:0] == 2'b00));
   assign byte_lsb    = {k_q, 3'b000};

   lsu_load_extend u_load_extend (
      .funct3_i (funct3_q),
      .value_i  (asm_q),
      .result_o (ext_rdata)
   );

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         store_q  <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         k_q      <= 2'd0;
         last_q   <= 2'd0;
         split_q  <= 1'b0;
         err_q    <= 1'b0;
         asm_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         k_q      <= k_d;
         last_q   <= last_d;
         split_q  <= split_d;
         err_q    <= err_d;
         asm_q    <= asm_d;
      end
   end

   // NOTE: every signal written here gets a default first; a missed branch would infer a latch.
   always_comb begin
      state_d  = state_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      k_d      = k_q;
      last_d   = last_q;
      split_d  = split_q;
      err_d    = err_q;
      asm_d    = asm_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               store_d  = req_store;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               k_d      = 2'd0;
               asm_d    = 32'd0;
               split_d  = !req_aligned;
               last_d   = req_aligned ? 2'd0 : 2'(req_size - 3'd1);
               if (!funct3_legal(req_store, req_funct3) || (!req_aligned && !SPLIT_MISALIGNED)) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!store_q) begin
               if (split_q) begin
                  asm_d[byte_lsb +: 8] = mem_data_read[7:0];
               end else begin
                  asm_d = mem_data_read;
               end
            end
            k_d = k_q + 2'd1;
            if (k_q == last_q) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory and response outputs decode straight from the state, so an
   // asynchronous reset drops the write enable immediately.
   always_comb begin
      req_ready      = (state_q == IDLE);
      resp_valid     = 1'b0;
      resp_rdata     = 32'd0;
      resp_err       = 1'b0;
      mem_MemRead    = 1'b0;
      mem_MemWr      = 1'b0;
      mem_addr       = '0;
      mem_funct3     = 3'd0;
      mem_write_data = 32'd0;
      case (state_q)
         ACCESS: begin
            mem_MemRead = !store_q;
            mem_MemWr   = store_q;
            if (split_q) begin
               mem_addr       = addr_q + ADDR_W'(k_q);
               mem_funct3     = store_q ? SB : LBU;
               mem_write_data = store_q ? {24'd0, wdata_q[byte_lsb +: 8]} : 32'd0;
            end else begin
               mem_addr       = addr_q;
               mem_funct3     = funct3_q;
               mem_write_data = store_q ? wdata_q : 32'd0;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (!err_q && !store_q) begin
               resp_rdata = split_q ? ext_rdata : asm_q;
            end
         end
         default: ;
      endcase
   end

endmodule
